// File: rtl/sup1_pkg.sv
// sup1_pkg: shared SUP-1 constants, control-bit positions and loader state encoding
package sup1_pkg;

    localparam int BUS_W     = 8;
    localparam int RAM_AW    = 4;
    localparam int RAM_DEPTH = 1 << RAM_AW;

    // Control-word bit positions, shared with the control unit
    localparam int CTL_HLT = 0;
    localparam int CTL_MI  = 1;
    localparam int CTL_RI  = 2;
    localparam int CTL_RO  = 3;
    localparam int CTL_PCC = 4;
    localparam int CTL_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_WAIT,
        ST_ADDR,
        ST_DATA,
        ST_VERIFY,
        ST_FINISH
    } ld_state_t;

endpackage

// File: rtl/mem_loader.sv
// mem_loader: boot loader that freezes the CPU, streams bytes into RAM over the shared bus, then clears PC
// Optional readback check enabled by defining LOADER_VERIFY_EN.
module mem_loader
    import sup1_pkg::*;
#(
    parameter int ADDR_W = RAM_AW,
    parameter int DATA_W = BUS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cpu_hold,
    input  logic              cpu_idle,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_in,
    output logic              mi,
    output logic              ri,
    output logic              ro,
    output logic              pc_clr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;
    logic [CTL_W-1:0]  ctl;

    // Next-state, counter and data-register logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (start) begin
                addr_d  = '0;
                rem_d   = (len > DEPTH) ? DEPTH : len;
                zero_d  = (len == '0);
                err_d   = 1'b0;
                state_d = (len == '0) ? ST_FINISH : ST_HOLD;
            end
            ST_HOLD: state_d = cpu_idle ? ST_WAIT : ST_HOLD;
            ST_WAIT: if (in_valid) begin
                data_d  = in_data;
                state_d = ST_ADDR;
            end
            ST_ADDR: state_d = ST_DATA;
            ST_DATA: begin
                addr_d  = addr_q + ADDR_W'(1);
                rem_d   = rem_q - ONE;
`ifdef LOADER_VERIFY_EN
                state_d = ST_VERIFY;
`else
                state_d = (rem_q == ONE) ? ST_FINISH : ST_WAIT;
`endif
            end
`ifdef LOADER_VERIFY_EN
            ST_VERIFY: begin
                err_d   = err_q | (bus_in != data_q);
                state_d = (rem_q == '0) ? ST_FINISH : ST_WAIT;
            end
`endif
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    // Control strobes decoded from the registered state, so each is stable for a whole cycle
    always_comb begin
        ctl          = '0;
        ctl[CTL_HLT] = (state_q != ST_IDLE) && (state_q != ST_FINISH);
        ctl[CTL_MI]  = (state_q == ST_ADDR);
        ctl[CTL_RI]  = (state_q == ST_DATA);
`ifdef LOADER_VERIFY_EN
        ctl[CTL_RO]  = (state_q == ST_VERIFY);
`endif
        ctl[CTL_PCC] = (state_q == ST_FINISH) && !zero_q;
    end

`ifndef LOADER_VERIFY_EN
    logic unused_bus;
    assign unused_bus = ^bus_in;
`endif

    assign cpu_hold = ctl[CTL_HLT];
    assign mi       = ctl[CTL_MI];
    assign ri       = ctl[CTL_RI];
    assign ro       = ctl[CTL_RO];
    assign pc_clr   = ctl[CTL_PCC];
    assign in_ready = (state_q == ST_WAIT);
    assign bus_oe   = mi | ri;
    assign bus_out  = mi ? DATA_W'(addr_q) : (ri ? data_q : '0);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FINISH);
    assign err      = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed test of mem_loader against a small bus/MAR/RAM model
module tb_mem_loader;

`ifdef LOADER_VERIFY_EN
    localparam int BPB = 4;
`else
    localparam int BPB = 3;
`endif

    logic       clk, rst_n, start, in_valid, cpu_idle;
    logic [4:0] len;
    logic [7:0] in_data, bus_out, bus_in;
    logic       in_ready, cpu_hold, bus_oe, mi, ri, ro, pc_clr, busy, done, err;

    logic [7:0]  ram [16];
    logic [3:0]  mar;
    logic [11:0] wq [$];
    logic [3:0]  mq [$];
    logic [7:0]  src [16];
    int cyc, onehot_bad, ro_cnt, pre_bad;
    int checks, errors;
    int lat, b, m;
    logic done_seen, done_pc, done_hold, done_err;

    mem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cpu_hold(cpu_hold), .cpu_idle(cpu_idle),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
        .mi(mi), .ri(ri), .ro(ro), .pc_clr(pc_clr),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus model; readback of address 1 has bit 0 flipped
    assign bus_in = bus_oe ? bus_out : (ro ? (ram[mar] ^ {7'd0, mar == 4'd1}) : 8'h00);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mi) begin
            mar <= bus_out[3:0];
            mq.push_back(bus_out[3:0]);
        end
        if (ri) begin
            ram[mar] <= bus_out;
            wq.push_back({mar, bus_out});
        end
        if (ro) ro_cnt <= ro_cnt + 1;
        if (32'(mi) + 32'(ri) + 32'(ro) > 1) onehot_bad <= onehot_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int l, input int n, input int gdly, input int gap);
        int t0, t;
        cpu_idle = (gdly == 0);
        start = 1'b1;
        len = l[4:0];
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        in_valid = (n > 0);
        in_data = src[0];
        for (int k = 0; k < gdly; k++) begin
            if (in_ready || bus_oe) pre_bad++;
            @(posedge clk); #1;
        end
        cpu_idle = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = src[i];
            t = 0;
            while (!in_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) check("hs_timeout", 0, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        t = 0;
        while (!done && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        lat = cyc - t0;
        done_seen = done;
        done_pc = pc_clr;
        done_hold = cpu_hold;
        done_err = err;
        @(posedge clk); #1;
        cpu_idle = 1'b0;
    endtask

    initial begin
        int t;
        checks = 0; errors = 0; pre_bad = 0;
        rst_n = 1'b0; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; cpu_idle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {in_ready, cpu_hold, bus_out, bus_oe, mi, ri, ro, pc_clr, busy, done, err}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        src[0] = 8'h1E; src[1] = 8'h2F; src[2] = 8'hF0;
        b = wq.size(); m = mq.size();
        load(3, 3, 2, 0);
        check("basic_nwr", wq.size() - b, 3);
        check("basic_wr0", wq[b], 12'h01E);
        check("basic_wr1", wq[b+1], 12'h12F);
        check("basic_wr2", wq[b+2], 12'h2F0);
        check("basic_mi0", mq[m], 0);
        check("basic_mi1", mq[m+1], 1);
        check("basic_mi2", mq[m+2], 2);
        check("basic_done", done_seen, 1);
        check("basic_pcclr", done_pc, 1);
        check("basic_hold", done_hold, 0);
        check("basic_lat", lat, 2 + 1 + BPB * 3);
        check("basic_idle", {busy, done}, 0);

        src[0] = 8'h01; src[1] = 8'h02;
        load(2, 2, 0, 0);
        check("min_lat", lat, 1 + BPB * 2);

        b = wq.size(); m = mq.size();
        load(0, 0, 0, 0);
        check("zero_lat", lat, 0);
        check("zero_done", done_seen, 1);
        check("zero_pcclr", done_pc, 0);
        check("zero_hold", done_hold, 0);
        check("zero_nostrobe", (wq.size() - b) + (mq.size() - m), 0);
        check("zero_after", {busy, done}, 0);

        src[0] = 8'h71; src[1] = 8'h72; src[2] = 8'h73;
        b = wq.size(); pre_bad = 0;
        load(3, 3, 10, 1);
        check("bp_pregrant", pre_bad, 0);
        check("bp_nwr", wq.size() - b, 3);
        check("bp_wr0", wq[b], 12'h071);
        check("bp_wr1", wq[b+1], 12'h172);
        check("bp_wr2", wq[b+2], 12'h273);
        check("bp_done", done_seen, 1);

        for (int i = 0; i < 16; i++) src[i] = 8'hA0 + 8'(i);
        b = wq.size();
        load(20, 16, 0, 0);
        check("sat_nwr", wq.size() - b, 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("sat_wr%0d", i), wq[b+i], {4'(i), 8'hA0 + 8'(i)});
        check("sat_done", done_seen, 1);

        cpu_idle = 1'b1;
        start = 1'b1; len = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        in_data = 8'h22;
        t = 0;
        while (!(ri && bus_out == 8'h22) && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        check("rst_reached", {ri, bus_out}, {1'b1, 8'h22});
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_outs", {in_ready, cpu_hold, bus_out, bus_oe, mi, ri, ro, pc_clr, busy, done, err}, 0);
        check("rst_busy", busy, 0);
        check("rst_ram0", ram[0], 8'h11);
        rst_n = 1'b1;
        cpu_idle = 1'b0;
        @(posedge clk); #1;

`ifdef LOADER_VERIFY_EN
        src[0] = 8'h5A; src[1] = 8'h5B; src[2] = 8'h5C;
        load(3, 3, 0, 0);
        check("ver_err_done", done_err, 1);
        check("ver_err_sticky", err, 1);
        load(0, 0, 0, 0);
        check("ver_err_clr", done_err, 0);
`else
        check("nover_err", err, 0);
        check("nover_ro", ro_cnt, 0);
`endif
        check("onehot", onehot_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        cyc = 0; onehot_bad = 0; ro_cnt = 0;
    end

endmodule
